multicycle_mem_core: RTL and testbench
======================================

// Module: multicycle_mem_core
// PURPOSE
// - Multicycle successor to the single-cycle lw/sw lab datapath. It accepts one 32-bit MIPS-style instruction per valid/ready handshake.
// - Executes LW/SW/ADDI through a state machine using an internal register file and data memory.
// - Exposes probe and debug-preload ports so the board top or a bench can observe and seed state.
// - Sits between the switch/instruction source and the 7-segment display drivers.
// PARAMETERS
// DATA_W     32  datapath, register and memory word width (>=16)
// REG_N      32  register count, power of 2; REG_AW=$clog2(REG_N), at most 5
// MEM_DEPTH  64  data-memory words, power of 2; MEM_AW=$clog2(MEM_DEPTH)
// PORTS
// clk            in   1       rising-edge clock
// rst            in   1       synchronous, active-high reset
// instr          in   32      instruction: op[31:26] rs[25:21] rt[20:16] imm[15:0]
// instr_valid    in   1       instr is presented
// instr_ready    out  1       core can accept; high only in IDLE
// dbg_we         in   1       debug write strobe; honoured only in IDLE when instr_valid=0
// dbg_sel        in   1       0=register file, 1=data memory
// dbg_addr       in   MEM_AW  debug target index (low REG_AW bits for registers)
// dbg_wdata      in   DATA_W  debug write data
// probe_reg_addr in   REG_AW  combinational probe index into the register file
// probe_reg_data out  DATA_W  value of register probe_reg_addr
// probe_mem_addr in   MEM_AW  combinational probe index into data memory
// probe_mem_data out  DATA_W  value of data memory at probe_mem_addr
// alu_result     out  DATA_W  registered ALU output of the last EXEC
// read_data      out  DATA_W  registered memory data of the last LW
// done           out  1       one-cycle pulse when an instruction retires or faults
// err            out  1       qualifies done: instruction faulted, no state changed
// err_code       out  2       1=illegal opcode, 2=address out of range, 0=none
// retired        out  16      count of error-free retirements; wraps 0xFFFF->0
// BEHAVIOUR
// - Opcodes: LW=6'b010101, SW=6'b010100, ADDI=6'b001000; any other opcode is illegal.
// - Reset: state=IDLE; all registers, memory, alu_result, read_data, retired, err and err_code are 0; done=0. Reset mid-instruction aborts it with no pulse.
// - FSM:
//   - IDLE: instr_valid&instr_ready latches instr -> DECODE.
//   - DECODE: A<=R[rs], B<=R[rt]. Illegal opcode -> DONE with err=1, code 1. Otherwise -> EXEC.
//   - EXEC: alu_result<=A+signext(imm), modulo 2^DATA_W. ADDI -> WB.
//     - LW/SW with alu_result[DATA_W-1:MEM_AW]!=0 -> DONE with err=1, code 2.
//     - Otherwise -> MEM.
//   - MEM: SW writes mem[alu_result[MEM_AW-1:0]]<=B -> DONE. LW: read_data<=mem[addr] -> WB.
//   - WB: R[rt]<=(LW ? read_data : alu_result) -> DONE.
//   - DONE: done=1 for one cycle, err/err_code valid. retired+=1 if err=0. -> IDLE.
// - err/err_code hold until the next acceptance, which clears them.
// - Latency from accept edge to done-high cycle: ADDI 4, SW 4, LW 5, faults 2 (illegal) or 3 (range).
// - Register 0 reads 0 and ignores writes, including debug writes; rs=rt=0 is legal.
// - rs==rt uses the pre-instruction value for both operands.
// - dbg_we with instr_valid=1 in IDLE: the instruction wins, the debug write is dropped. dbg_we outside IDLE is ignored.
// - Probes are combinational reads. A probe shows the new value in the cycle after the write edge.
// STRUCTURE
// - Package mcore_pkg: opcode localparams, state_t enum (IDLE, DECODE, EXEC, MEM, WB, DONE), err_code localparams.
// - Sub-module mcore_regfile: REG_N x DATA_W, two read ports, one probe read port, one write port, r0 hardwired to 0.
// - Memory array, ALU add and FSM live in this module.
// TESTING
// - Reset, then dbg write mem[5]=0x1234. Issue 0x54010005 (LW r1,5(r0)). done is high in the 5th cycle after accept, R1=0x1234, read_data=0x1234, retired=1.
// - dbg R9=0xCAFE. Issue 0x50090002 (SW r9,2(r0)). done is high 4 cycles after accept, mem[2]=0xCAFE, no register changed.
// - Issue ADDI r3,r0,-1 (0x2003FFFF). R3=0xFFFFFFFF. Then ADDI r0,r0,7: R0 stays 0 and retired still increments.
// - LW with address 64 (MEM_DEPTH=64). done with err=1, code 2, 3 cycles after accept. No register changed, retired unchanged.
// - Opcode 6'b111111: done with err=1, code 1, 2 cycles after accept. The next legal instruction clears err.
// - Assert rst during the MEM state of an SW: no memory write, outputs return to reset values, instr_ready=1 the next cycle.

Source files
------------

// File: rtl/mcore_pkg.sv
// Shared definitions for the multicycle LW/SW/ADDI core: opcodes, FSM states
// and fault codes.
package mcore_pkg;

    localparam logic [5:0] OP_LW   = 6'b010101;
    localparam logic [5:0] OP_SW   = 6'b010100;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_RANGE   = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB,
        DONE
    } state_t;

    // True for the three opcodes the core knows how to execute.
    function automatic logic isLegalOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mcore_regfile.sv
// Register file for the multicycle core: two operand read ports, one probe
// read port and one write port. Register 0 always reads as zero and silently
// drops writes, whoever issues them.
module mcore_regfile
    import mcore_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int REG_N  = 32,
    localparam int REG_AW = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] i_rdAddrA,
    input  logic [REG_AW-1:0] i_rdAddrB,
    input  logic [REG_AW-1:0] i_probeAddr,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    output logic [DATA_W-1:0] o_rdDataA,
    output logic [DATA_W-1:0] o_rdDataB,
    output logic [DATA_W-1:0] o_probeData
);

    logic [DATA_W-1:0] r_regs [REG_N];

    // Clear every register on reset, otherwise commit one write unless it targets r0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wrAddr != '0)) begin
            r_regs[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdDataA   = (i_rdAddrA   == '0) ? '0 : r_regs[i_rdAddrA];
    assign o_rdDataB   = (i_rdAddrB   == '0) ? '0 : r_regs[i_rdAddrB];
    assign o_probeData = (i_probeAddr == '0) ? '0 : r_regs[i_probeAddr];

endmodule

// File: rtl/multicycle_mem_core.sv
// Multicycle MIPS-style core executing LW, SW and ADDI one instruction per
// handshake. Holds the data memory, the address adder and the control FSM;
// the register file lives in mcore_regfile. Debug and probe ports let a board
// top or bench seed and observe architectural state.
module multicycle_mem_core
    import mcore_pkg::*;
#(
    parameter  int DATA_W    = 32,
    parameter  int REG_N     = 32,
    parameter  int MEM_DEPTH = 64,
    localparam int REG_AW    = $clog2(REG_N),
    localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              dbg_we,
    input  logic              dbg_sel,
    input  logic [MEM_AW-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    input  logic [REG_AW-1:0] probe_reg_addr,
    output logic [DATA_W-1:0] probe_reg_data,
    input  logic [MEM_AW-1:0] probe_mem_addr,
    output logic [DATA_W-1:0] probe_mem_data,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] read_data,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [15:0]       retired
);

    state_t            r_state;
    state_t            w_nextState;

    logic [31:0]       r_instr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_aluResult;
    logic [DATA_W-1:0] r_readData;
    logic              r_err;
    logic [1:0]        r_errCode;
    logic [15:0]       r_retired;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic [5:0]        w_op;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [15:0]       w_imm;
    logic [DATA_W-1:0] w_immExt;
    logic [DATA_W-1:0] w_aluSum;
    logic              w_rangeFault;
    logic [MEM_AW-1:0] w_memAddr;
    logic              w_dbgWrite;
    logic [DATA_W-1:0] w_rfDataA;
    logic [DATA_W-1:0] w_rfDataB;

    logic              w_rfWe;
    logic [REG_AW-1:0] w_rfWaddr;
    logic [DATA_W-1:0] w_rfWdata;
    logic              w_memWe;
    logic [MEM_AW-1:0] w_memWaddr;
    logic [DATA_W-1:0] w_memWdata;
    logic              w_unusedBits;

    assign w_op  = r_instr[31:26];
    assign w_rs  = r_instr[25:21];
    assign w_rt  = r_instr[20:16];
    assign w_imm = r_instr[15:0];

    assign w_immExt     = DATA_W'(signed'(w_imm));
    assign w_aluSum     = r_a + w_immExt;
    // Any set bit above the memory index means the address falls off the array.
    assign w_rangeFault = (w_aluSum >> MEM_AW) != '0;
    assign w_memAddr    = r_aluResult[MEM_AW-1:0];

    // A debug write only lands when the core is idle and no instruction competes.
    assign w_dbgWrite   = (r_state == IDLE) && dbg_we && !instr_valid;

    // Field bits beyond the configured register index width are deliberately ignored.
    assign w_unusedBits = ^{dbg_addr, w_rs, w_rt};

    mcore_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rdAddrA   (w_rs[REG_AW-1:0]),
        .i_rdAddrB   (w_rt[REG_AW-1:0]),
        .i_probeAddr (probe_reg_addr),
        .i_we        (w_rfWe),
        .i_wrAddr    (w_rfWaddr),
        .i_wrData    (w_rfWdata),
        .o_rdDataA   (w_rfDataA),
        .o_rdDataB   (w_rfDataB),
        .o_probeData (probe_reg_data)
    );

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state selection plus the handshake and retire strobes.
    always_comb begin
        w_nextState = r_state;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_nextState = DECODE;
                end
            end
            DECODE: begin
                w_nextState = isLegalOp(w_op) ? EXEC : DONE;
            end
            EXEC: begin
                if (w_op == OP_ADDI) begin
                    w_nextState = WB;
                end else if (w_rangeFault) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = MEM;
                end
            end
            MEM: begin
                w_nextState = (w_op == OP_LW) ? WB : DONE;
            end
            WB: begin
                w_nextState = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Write-port steering: writeback owns the register file outside IDLE, debug inside it.
    always_comb begin
        w_rfWe     = 1'b0;
        w_rfWaddr  = '0;
        w_rfWdata  = '0;
        w_memWe    = 1'b0;
        w_memWaddr = '0;
        w_memWdata = '0;
        if (r_state == WB) begin
            w_rfWe    = 1'b1;
            w_rfWaddr = w_rt[REG_AW-1:0];
            w_rfWdata = (w_op == OP_LW) ? r_readData : r_aluResult;
        end else if (w_dbgWrite && !dbg_sel) begin
            w_rfWe    = 1'b1;
            w_rfWaddr = dbg_addr[REG_AW-1:0];
            w_rfWdata = dbg_wdata;
        end
        if ((r_state == MEM) && (w_op == OP_SW)) begin
            w_memWe    = 1'b1;
            w_memWaddr = w_memAddr;
            w_memWdata = r_b;
        end else if (w_dbgWrite && dbg_sel) begin
            w_memWe    = 1'b1;
            w_memWaddr = dbg_addr;
            w_memWdata = dbg_wdata;
        end
    end

    // Data memory: cleared on reset, one write per cycle from SW or debug.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_memWe) begin
            r_mem[w_memWaddr] <= w_memWdata;
        end
    end

    // Datapath registers, fault status and the retirement counter, advanced per state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_aluResult <= '0;
            r_readData  <= '0;
            r_err       <= 1'b0;
            r_errCode   <= ERR_NONE;
            r_retired   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (instr_valid) begin
                        r_instr   <= instr;
                        r_err     <= 1'b0;
                        r_errCode <= ERR_NONE;
                    end
                end
                DECODE: begin
                    r_a <= w_rfDataA;
                    r_b <= w_rfDataB;
                    if (!isLegalOp(w_op)) begin
                        r_err     <= 1'b1;
                        r_errCode <= ERR_ILLEGAL;
                    end
                end
                EXEC: begin
                    r_aluResult <= w_aluSum;
                    if ((w_op != OP_ADDI) && w_rangeFault) begin
                        r_err     <= 1'b1;
                        r_errCode <= ERR_RANGE;
                    end
                end
                MEM: begin
                    if (w_op == OP_LW) begin
                        r_readData <= r_mem[w_memAddr];
                    end
                end
                DONE: begin
                    if (!r_err) begin
                        r_retired <= r_retired + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign alu_result     = r_aluResult;
    assign read_data      = r_readData;
    assign err            = r_err;
    assign err_code       = r_errCode;
    assign retired        = r_retired;
    assign probe_mem_data = r_mem[probe_mem_addr];

endmodule

// File: tb/tb_multicycle_mem_core.sv
// Self-checking bench for multicycle_mem_core: directed scenarios plus a
// randomized instruction stream compared against an architectural model.
module tb_multicycle_mem_core;

    localparam logic [5:0] LW_OP   = 6'b010101;
    localparam logic [5:0] SW_OP   = 6'b010100;
    localparam logic [5:0] ADDI_OP = 6'b001000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        dbg_we;
    logic        dbg_sel;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic [4:0]  probe_reg_addr;
    logic [31:0] probe_reg_data;
    logic [5:0]  probe_mem_addr;
    logic [31:0] probe_mem_data;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] retired;

    // Architectural model state.
    logic [31:0] mReg [32];
    logic [31:0] mMem [64];
    logic [31:0] mAlu;
    logic [31:0] mRd;
    logic [15:0] mRetired;

    int nVec  = 0;
    int nMiss = 0;

    multicycle_mem_core dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .dbg_we         (dbg_we),
        .dbg_sel        (dbg_sel),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .probe_reg_addr (probe_reg_addr),
        .probe_reg_data (probe_reg_data),
        .probe_mem_addr (probe_mem_addr),
        .probe_mem_data (probe_mem_data),
        .alu_result     (alu_result),
        .read_data      (read_data),
        .done           (done),
        .err            (err),
        .err_code       (err_code),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMiss++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = '0;
        for (int i = 0; i < 64; i++) mMem[i] = '0;
        mAlu     = '0;
        mRd      = '0;
        mRetired = '0;
    endtask

    task automatic dbgWrite(input logic sel, input logic [5:0] addr, input logic [31:0] data);
        @(negedge clk);
        dbg_we    = 1'b1;
        dbg_sel   = sel;
        dbg_addr  = addr;
        dbg_wdata = data;
        @(posedge clk);
        #1 dbg_we = 1'b0;
        if (sel) mMem[addr] = data;
        else if (addr[4:0] != 5'd0) mReg[addr[4:0]] = data;
    endtask

    task automatic probeReg(input logic [4:0] idx, output logic [31:0] val);
        probe_reg_addr = idx;
        #1 val = probe_reg_data;
    endtask

    task automatic probeMem(input logic [5:0] idx, output logic [31:0] val);
        probe_mem_addr = idx;
        #1 val = probe_mem_data;
    endtask

    // Issue one instruction, predict its architectural effect, and check timing and state.
    task automatic applyStimulus(input logic [31:0] ins, input logic withDbg);
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [31:0] sx, a, b, sum, val;
        int          expLat, memIdx, cycles, randIdx;
        logic        expErr, got;
        logic [1:0]  expCode;

        op     = ins[31:26];
        rs     = ins[25:21];
        rt     = ins[20:16];
        sx     = {{16{ins[15]}}, ins[15:0]};
        a      = mReg[rs];
        b      = mReg[rt];
        memIdx = -1;
        expErr = 1'b0;
        expCode = 2'd0;
        if (op != LW_OP && op != SW_OP && op != ADDI_OP) begin
            expLat  = 2;
            expErr  = 1'b1;
            expCode = 2'd1;
        end else begin
            sum  = a + sx;
            mAlu = sum;
            if (op == ADDI_OP) begin
                expLat = 4;
                if (rt != 5'd0) mReg[rt] = sum;
            end else if (sum >= 32'd64) begin
                expLat  = 3;
                expErr  = 1'b1;
                expCode = 2'd2;
            end else if (op == SW_OP) begin
                expLat = 4;
                memIdx = int'(sum);
                mMem[sum[5:0]] = b;
            end else begin
                expLat = 5;
                memIdx = int'(sum);
                mRd    = mMem[sum[5:0]];
                if (rt != 5'd0) mReg[rt] = mRd;
            end
        end
        if (!expErr) mRetired = mRetired + 16'd1;

        @(negedge clk);
        checkOutput("ready_idle", {31'b0, instr_ready}, 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        if (withDbg) begin
            dbg_we    = 1'b1;
            dbg_sel   = 1'b0;
            dbg_addr  = 6'd10;
            dbg_wdata = 32'h5555_5555;
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        dbg_we      = 1'b0;

        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 12) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                checkOutput("ready_busy", {31'b0, instr_ready}, 32'd0);
                checkOutput("err_cleared", {31'b0, err}, 32'd0);
            end
            if (done) begin
                got = 1'b1;
                checkOutput("err", {31'b0, err}, {31'b0, expErr});
                checkOutput("err_code", {30'b0, err_code}, {30'b0, expCode});
            end
        end
        checkOutput("latency", 32'(cycles), 32'(expLat));

        @(negedge clk);
        checkOutput("done_pulse", {31'b0, done}, 32'd0);
        checkOutput("retired", {16'b0, retired}, {16'b0, mRetired});
        checkOutput("alu_result", alu_result, mAlu);
        checkOutput("read_data", read_data, mRd);
        probeReg(rt, val);
        checkOutput("reg_rt", val, mReg[rt]);
        randIdx = $urandom_range(0, 31);
        probeReg(5'(randIdx), val);
        checkOutput("reg_any", val, mReg[randIdx]);
        if (memIdx < 0) memIdx = $urandom_range(0, 63);
        probeMem(6'(memIdx), val);
        checkOutput("mem", val, mMem[memIdx]);
    endtask

    // Build a random instruction biased toward in-range memory accesses.
    function automatic logic [31:0] randomInstr();
        int          sel;
        logic [5:0]  op;
        logic [4:0]  rs, rt;
        logic [15:0] imm;
        sel = $urandom_range(0, 9);
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        if (sel <= 5) begin
            op  = (sel <= 2) ? LW_OP : SW_OP;
            imm = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
        end else if (sel <= 8) begin
            op  = ADDI_OP;
            imm = 16'($urandom_range(0, 40)) - 16'd20;
        end else begin
            op = 6'($urandom);
            while (op == LW_OP || op == SW_OP || op == ADDI_OP) op = 6'($urandom);
            imm = 16'($urandom);
        end
        return {op, rs, rt, imm};
    endfunction

    initial begin
        logic [31:0] val;
        int          cyc;

        rst            = 1'b1;
        instr          = '0;
        instr_valid    = 1'b0;
        dbg_we         = 1'b0;
        dbg_sel        = 1'b0;
        dbg_addr       = '0;
        dbg_wdata      = '0;
        probe_reg_addr = '0;
        probe_mem_addr = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        checkOutput("rst_ready", {31'b0, instr_ready}, 32'd1);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_code", {30'b0, err_code}, 32'd0);
        checkOutput("rst_retired", {16'b0, retired}, 32'd0);
        checkOutput("rst_alu", alu_result, 32'd0);
        checkOutput("rst_rdata", read_data, 32'd0);
        probeMem(6'd5, val);
        checkOutput("rst_mem5", val, 32'd0);

        // LW r1,5(r0) after seeding memory.
        dbgWrite(1'b1, 6'd5, 32'h0000_1234);
        applyStimulus(32'h5401_0005, 1'b0);
        // SW r9,2(r0) after seeding r9.
        dbgWrite(1'b0, 6'd9, 32'h0000_CAFE);
        applyStimulus(32'h5009_0002, 1'b0);
        // ADDI r3,r0,-1 then ADDI r0,r0,7.
        applyStimulus(32'h2003_FFFF, 1'b0);
        applyStimulus(32'h2000_0007, 1'b0);
        // LW r1,64(r0): address out of range.
        applyStimulus(32'h5401_0040, 1'b0);
        // Illegal opcode followed by a legal instruction.
        applyStimulus(32'hFC00_0000, 1'b0);
        applyStimulus(32'h2004_0005, 1'b0);
        // Debug write to r0 is ignored.
        dbgWrite(1'b0, 6'd0, 32'hDEAD_BEEF);
        probeReg(5'd0, val);
        checkOutput("r0_dbg", val, 32'd0);
        // Debug write colliding with an instruction is dropped.
        applyStimulus(32'h2005_0011, 1'b1);
        probeReg(5'd10, val);
        checkOutput("dbg_dropped", val, mReg[10]);

        // Random stream over a small register window.
        for (int i = 1; i < 8; i++) dbgWrite(1'b0, 6'(i), 32'($urandom_range(0, 70)));
        for (int i = 0; i < 8; i++) dbgWrite(1'b1, 6'($urandom_range(0, 63)), $urandom);
        for (int n = 0; n < 60; n++) applyStimulus(randomInstr(), 1'b0);

        // Reset asserted while an SW sits in MEM.
        @(negedge clk);
        instr       = 32'h5009_000A;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        cyc = 0;
        repeat (3) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        modelReset();
        checkOutput("midrst_ready", {31'b0, instr_ready}, 32'd1);
        checkOutput("midrst_done", {31'b0, done}, 32'd0);
        checkOutput("midrst_retired", {16'b0, retired}, 32'd0);
        checkOutput("midrst_alu", alu_result, 32'd0);
        probeMem(6'd10, val);
        checkOutput("midrst_mem10", val, 32'd0);
        probeReg(5'd9, val);
        checkOutput("midrst_r9", val, 32'd0);
        rst = 1'b0;
        applyStimulus(32'h2005_0003, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
